uriscv_muldiv_issue: RTL

Requester-side controller for uriscv_muldiv. It accepts one decoded M-extension op from the execute stage and drives the unit's valid/one-hot-op/operand interface, respecting stall_o. It waits for ready_o, captures the result, and presents it to the register-file writeback port with the destination register tagged. It also watches the unit with a timeout.

---
 rtl/uriscv_muldiv_pkg.sv | 42 ++++
 rtl/uriscv_muldiv_watchdog.sv | 39 +++
 rtl/uriscv_muldiv_issue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uriscv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uriscv_muldiv_pkg
// Purpose  : Shared types and helpers for the muldiv issue controller:
//            funct3 op encoding, controller states, one-hot op decode.
// Revision : 1.0 - initial release
// ============================================================================
package uriscv_muldiv_pkg;

    // funct3 encoding of the RV32M operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    // Issue controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_e;

    // Smallest legal watchdog limit: the divider needs 33+ cycles
    localparam int MIN_TIMEOUT = 34;

    // Bit n set for funct3 value n (bit 0 = MUL ... bit 7 = REMU)
    function automatic logic [7:0] op_to_onehot(muldiv_op_e op);
        logic [7:0] w_onehot;
        w_onehot     = 8'd0;
        w_onehot[op] = 1'b1;
        return w_onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uriscv_muldiv_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : uriscv_muldiv_watchdog
// Purpose  : Clear/enable cycle counter. expire_o flags the enabled
//            increment that brings the count up to TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module uriscv_muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Counter: clear has priority, then saturating increment at the limit
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i && (r_count != C_LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Terminal count: this cycle's increment reaches the limit
    assign expire_o = enable_i && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uriscv_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : uriscv_muldiv_issue
// Purpose  : Requester-side controller for uriscv_muldiv. Accepts one op,
//            issues a single valid pulse with one-hot op, waits for the
//            result under a watchdog and hands it to register writeback.
// Revision : 1.0 - initial release
// ============================================================================
module uriscv_muldiv_issue
    import uriscv_muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // execute-stage request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_ra_i,
    input  logic [31:0] req_rb_i,
    input  logic [4:0]  req_rd_i,
    // muldiv unit interface
    output logic        valid_o,
    output logic        inst_mul_o,
    output logic        inst_mulh_o,
    output logic        inst_mulhsu_o,
    output logic        inst_mulhu_o,
    output logic        inst_div_o,
    output logic        inst_divu_o,
    output logic        inst_rem_o,
    output logic        inst_remu_o,
    output logic [31:0] operand_ra_o,
    output logic [31:0] operand_rb_o,
    input  logic        stall_i,
    input  logic        ready_i,
    input  logic [31:0] result_i,
    // register-file writeback
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    // status
    output logic        busy_o,
    output logic        error_o
);

    state_e      r_state;
    state_e      w_state_next;
    muldiv_op_e  r_op;
    logic [31:0] r_ra;
    logic [31:0] r_rb;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;
    logic        r_error;

    logic        w_accept;
    logic        w_issue;
    logic        w_capture;
    logic        w_wd_enable;
    logic        w_wd_expire;
    logic        w_set_error;
    logic [7:0]  w_inst;

    // Watchdog counts WAIT cycles without ready; cleared on the issue pulse
    uriscv_muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (w_issue),
        .enable_i (w_wd_enable),
        .expire_o (w_wd_expire)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_wd_enable  = 1'b0;
        w_set_error  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Pulse only when the unit can take it; never valid while stalled
                if (!stall_i) begin
                    w_issue      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (ready_i) begin
                    w_capture    = 1'b1;
                    // x0 writes are discarded, so skip the writeback handshake
                    w_state_next = (r_rd == 5'd0) ? IDLE : WB;
                end else begin
                    w_wd_enable = 1'b1;
                    if (w_wd_expire) begin
                        w_set_error  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            WB: begin
                if (wb_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, result capture and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op      <= OP_MUL;
            r_ra      <= 32'd0;
            r_rb      <= 32'd0;
            r_rd      <= 5'd0;
            r_wb_data <= 32'd0;
            r_error   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= muldiv_op_e'(req_op_i);
                r_ra <= req_ra_i;
                r_rb <= req_rb_i;
                r_rd <= req_rd_i;
            end
            if (w_capture) begin
                r_wb_data <= result_i;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    assign w_inst        = op_to_onehot(r_op) & {8{w_issue}};

    assign valid_o       = w_issue;
    assign inst_mul_o    = w_inst[0];
    assign inst_mulh_o   = w_inst[1];
    assign inst_mulhsu_o = w_inst[2];
    assign inst_mulhu_o  = w_inst[3];
    assign inst_div_o    = w_inst[4];
    assign inst_divu_o   = w_inst[5];
    assign inst_rem_o    = w_inst[6];
    assign inst_remu_o   = w_inst[7];
    assign operand_ra_o  = r_ra;
    assign operand_rb_o  = r_rb;

    assign req_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign wb_valid_o    = (r_state == WB);
    assign wb_rd_o       = r_rd;
    assign wb_data_o     = r_wb_data;
    assign error_o       = r_error;

endmodule
`default_nettype wire
